// File: rtl/idct_col_seq.sv
// idct_col_seq: sequences one 4/8-point IDCT column through a shared coefficient multiplier,
// accumulates the partial products that return two cycles later, then butterflies, rounds and saturates.
module idct_col_seq #(
    parameter int WIDTH_X = 16,
    parameter int WIDTH_Y = 23,
    parameter int WIDTH_O = 16,
    parameter int SHIFT   = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_size,
    input  logic [8*WIDTH_X-1:0] in_coef,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_size,
    output logic [8*WIDTH_O-1:0] out_data,
    output logic [WIDTH_X-1:0]   mul_x,
    output logic [2:0]           mul_mode,
    output logic [1:0]           mul_tag,
    input  logic [1:0]           mul_tag_ret,
    input  logic [WIDTH_Y-1:0]   mul_y0,
    input  logic [WIDTH_Y-1:0]   mul_y1,
    input  logic [WIDTH_Y-1:0]   mul_y2,
    input  logic [WIDTH_Y-1:0]   mul_y3,
    output logic                 err
);

    localparam int AW = WIDTH_Y + 3;
    localparam int RW = WIDTH_Y + 6;
    localparam logic [1:0] TAG4 = 2'b01;
    localparam logic [1:0] TAG8 = 2'b10;
    localparam logic signed [RW-1:0] RND  = RW'(1) << (SHIFT - 1);
    localparam logic signed [RW-1:0] OMAX = (RW'(1) << (WIDTH_O - 1)) - RW'(1);
    localparam logic signed [RW-1:0] OMIN = RW'(0) - (RW'(1) << (WIDTH_O - 1));

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN,
        OUT
    } state_t;

    state_t state, state_nx;

    logic [2:0]           idx;
    logic [2:0]           last_idx;
    logic                 drain_cnt;
    logic                 size_q;
    logic [8*WIDTH_X-1:0] coef_q;

    logic       p1_vld, p2_vld;
    logic [2:0] p1_idx, p2_idx;
    logic [1:0] p1_tag, p2_tag;

    logic signed [AW-1:0] acc_e0, acc_e1, acc_f0, acc_f1;
    logic signed [AW-1:0] acc_o [4];
    logic signed [AW-1:0] y_ext [4];
    logic signed [RW-1:0] be [4];
    logic signed [RW-1:0] bo [4];
    logic signed [RW-1:0] r  [8];

    logic accept;

    assign accept   = (state == IDLE) && in_valid;
    assign last_idx = size_q ? 3'd7 : 3'd3;

    always_comb begin
        y_ext[0] = {{3{mul_y0[WIDTH_Y-1]}}, mul_y0};
        y_ext[1] = {{3{mul_y1[WIDTH_Y-1]}}, mul_y1};
        y_ext[2] = {{3{mul_y2[WIDTH_Y-1]}}, mul_y2};
        y_ext[3] = {{3{mul_y3[WIDTH_Y-1]}}, mul_y3};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_x     = '0;
        mul_mode  = '0;
        mul_tag   = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ISSUE;
            end
            ISSUE: begin
                mul_x    = coef_q[int'(idx)*WIDTH_X +: WIDTH_X];
                mul_mode = size_q ? idx : {1'b0, idx[1:0]};
                mul_tag  = size_q ? TAG8 : TAG4;
                if (idx == last_idx) state_nx = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt) state_nx = FIN;
            end
            FIN: begin
                state_nx = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Issue info delayed to match the multiplier latency; it alone decides when a return is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            drain_cnt <= 1'b0;
            size_q    <= 1'b0;
            coef_q    <= '0;
            p1_vld    <= 1'b0;
            p1_idx    <= '0;
            p1_tag    <= '0;
            p2_vld    <= 1'b0;
            p2_idx    <= '0;
            p2_tag    <= '0;
        end else begin
            p1_vld    <= (state == ISSUE);
            p1_idx    <= idx;
            p1_tag    <= mul_tag;
            p2_vld    <= p1_vld;
            p2_idx    <= p1_idx;
            p2_tag    <= p1_tag;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (accept) begin
                coef_q <= in_coef;
                size_q <= in_size;
                idx    <= '0;
            end else if (state == ISSUE) begin
                idx <= idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_e0 <= '0;
            acc_e1 <= '0;
            acc_f0 <= '0;
            acc_f1 <= '0;
            for (int unsigned k = 0; k < 4; k++) acc_o[k] <= '0;
        end else if (accept) begin
            acc_e0 <= '0;
            acc_e1 <= '0;
            acc_f0 <= '0;
            acc_f1 <= '0;
            for (int unsigned k = 0; k < 4; k++) acc_o[k] <= '0;
        end else if (p2_vld) begin
            if (size_q) begin
                case (p2_idx)
                    3'd0: begin acc_e0 <= acc_e0 + y_ext[0]; acc_e1 <= acc_e1 + y_ext[1]; end
                    3'd4: begin acc_e0 <= acc_e0 + y_ext[0]; acc_e1 <= acc_e1 - y_ext[1]; end
                    3'd2: begin acc_f0 <= acc_f0 + y_ext[0]; acc_f1 <= acc_f1 + y_ext[1]; end
                    3'd6: begin acc_f0 <= acc_f0 + y_ext[0]; acc_f1 <= acc_f1 - y_ext[1]; end
                    3'd1: begin
                        acc_o[0] <= acc_o[0] + y_ext[0];
                        acc_o[1] <= acc_o[1] + y_ext[1];
                        acc_o[2] <= acc_o[2] + y_ext[2];
                        acc_o[3] <= acc_o[3] + y_ext[3];
                    end
                    3'd3: begin
                        acc_o[0] <= acc_o[0] + y_ext[0];
                        acc_o[1] <= acc_o[1] - y_ext[1];
                        acc_o[2] <= acc_o[2] - y_ext[2];
                        acc_o[3] <= acc_o[3] - y_ext[3];
                    end
                    3'd5: begin
                        acc_o[0] <= acc_o[0] + y_ext[0];
                        acc_o[1] <= acc_o[1] - y_ext[1];
                        acc_o[2] <= acc_o[2] + y_ext[2];
                        acc_o[3] <= acc_o[3] + y_ext[3];
                    end
                    default: begin
                        acc_o[0] <= acc_o[0] + y_ext[0];
                        acc_o[1] <= acc_o[1] - y_ext[1];
                        acc_o[2] <= acc_o[2] + y_ext[2];
                        acc_o[3] <= acc_o[3] - y_ext[3];
                    end
                endcase
            end else begin
                case (p2_idx[1:0])
                    2'd0: begin acc_e0 <= acc_e0 + y_ext[0]; acc_e1 <= acc_e1 + y_ext[1]; end
                    2'd2: begin acc_e0 <= acc_e0 + y_ext[0]; acc_e1 <= acc_e1 - y_ext[1]; end
                    2'd1: begin acc_f0 <= acc_f0 + y_ext[0]; acc_f1 <= acc_f1 + y_ext[1]; end
                    default: begin acc_f0 <= acc_f0 + y_ext[0]; acc_f1 <= acc_f1 - y_ext[1]; end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (p2_vld && (mul_tag_ret != p2_tag)) begin
            err <= 1'b1;
        end
    end

    always_comb begin
        be[0] = RW'(acc_e0) + RW'(acc_f0);
        be[3] = RW'(acc_e0) - RW'(acc_f0);
        be[1] = RW'(acc_e1) + RW'(acc_f1);
        be[2] = RW'(acc_e1) - RW'(acc_f1);
        for (int unsigned k = 0; k < 4; k++) bo[k] = RW'(acc_o[k]);
        for (int unsigned k = 0; k < 8; k++) r[k] = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (size_q) begin
                r[k]     = be[k] + bo[k];
                r[7 - k] = be[k] - bo[k];
            end else begin
                r[k] = be[k];
            end
        end
    end

    function automatic logic [WIDTH_O-1:0] rnd_sat(input logic signed [RW-1:0] v);
        logic signed [RW-1:0] t;
        t = (v + RND) >>> SHIFT;
        if (t > OMAX) return OMAX[WIDTH_O-1:0];
        else if (t < OMIN) return OMIN[WIDTH_O-1:0];
        else return t[WIDTH_O-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_size <= 1'b0;
        end else if (state == FIN) begin
            for (int unsigned k = 0; k < 8; k++) out_data[k*WIDTH_O +: WIDTH_O] <= rnd_sat(r[k]);
            out_size <= size_q;
        end
    end

endmodule

// File: tb/tb_idct_col_seq.sv
// tb_idct_col_seq: drives columns into idct_col_seq with a modelled 2-cycle multiplier and
// scoreboards every output column against a direct matrix-product reference.
module tb_idct_col_seq;

    localparam int WX = 16;
    localparam int WY = 23;
    localparam int WO = 16;
    localparam int SH = 7;

    typedef struct packed {
        logic [8*WO-1:0] data;
        logic            size;
        logic [31:0]     acc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_size = 1'b0;
    logic [8*WX-1:0] in_coef = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_size;
    logic [8*WO-1:0] out_data;
    logic [WX-1:0]   mul_x;
    logic [2:0]      mul_mode;
    logic [1:0]      mul_tag;
    logic [1:0]      mul_tag_ret;
    logic [WY-1:0]   my [4];
    logic            err;

    logic [WX-1:0]   m1_x = '0;
    logic [2:0]      m1_mode = '0;
    logic [1:0]      m1_tag = '0;
    logic [1:0]      m_tag2 = '0;
    logic            corrupt = 1'b0;

    int   n_cmp = 0;
    int   n_mis = 0;
    int   edges = 0;
    int   hs_edge = -100;
    int   hold = 0;
    bit   stall_req = 1'b0;
    bit   prev_v = 1'b0;
    logic err_exp = 1'b0;
    logic [8*WO-1:0] held;
    exp_t q [$];

    int t8 [8][8] = '{
        '{64,  64,  64,  64,  64,  64,  64,  64},
        '{89,  75,  50,  18, -18, -50, -75, -89},
        '{83,  36, -36, -83, -83, -36,  36,  83},
        '{75, -18, -89, -50,  50,  89,  18, -75},
        '{64, -64, -64,  64,  64, -64, -64,  64},
        '{50, -89,  18,  75, -75, -18,  89, -50},
        '{36, -83,  83, -36, -36,  83, -83,  36},
        '{18, -50,  75, -89,  89, -75,  50, -18}
    };
    int t4 [4][4] = '{
        '{64,  64,  64,  64},
        '{83,  36, -36, -83},
        '{64, -64, -64,  64},
        '{36, -83,  83, -36}
    };

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    idct_col_seq #(.WIDTH_X(WX), .WIDTH_Y(WY), .WIDTH_O(WO), .SHIFT(SH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_size(in_size), .in_coef(in_coef),
        .out_valid(out_valid), .out_ready(out_ready), .out_size(out_size), .out_data(out_data),
        .mul_x(mul_x), .mul_mode(mul_mode), .mul_tag(mul_tag), .mul_tag_ret(mul_tag_ret),
        .mul_y0(my[0]), .mul_y1(my[1]), .mul_y2(my[2]), .mul_y3(my[3]),
        .err(err)
    );

    // Shared multiplier: magnitude of the coefficient feeding product k for a given tag/mode.
    function automatic int mag(input logic [1:0] tag, input logic [2:0] mode, input int k);
        int m [4];
        m = '{0, 0, 0, 0};
        if (tag == 2'b10) begin
            case (mode)
                3'd0, 3'd4: m = '{64, 64, 0, 0};
                3'd2:       m = '{83, 36, 0, 0};
                3'd6:       m = '{36, 83, 0, 0};
                3'd1:       m = '{89, 75, 50, 18};
                3'd3:       m = '{75, 18, 89, 50};
                3'd5:       m = '{50, 89, 18, 75};
                default:    m = '{18, 50, 75, 89};
            endcase
        end else if (tag == 2'b01) begin
            case (mode)
                3'd0, 3'd2: m = '{64, 64, 0, 0};
                3'd1:       m = '{83, 36, 0, 0};
                3'd3:       m = '{36, 83, 0, 0};
                default:    m = '{0, 0, 0, 0};
            endcase
        end
        return m[k];
    endfunction

    always @(posedge clk) begin
        m1_x    <= mul_x;
        m1_mode <= mul_mode;
        m1_tag  <= mul_tag;
        m_tag2  <= m1_tag;
        for (int k = 0; k < 4; k++) my[k] <= WY'(int'($signed(m1_x)) * mag(m1_tag, m1_mode, k));
    end

    assign mul_tag_ret = corrupt ? 2'b00 : m_tag2;

    function automatic logic [8*WO-1:0] ref_col(input logic size, input logic [8*WX-1:0] coef);
        logic [8*WO-1:0] res;
        int v;
        int s [8];
        res = '0;
        for (int n = 0; n < 8; n++) s[n] = int'($signed(coef[n*WX +: WX]));
        for (int k = 0; k < (size ? 8 : 4); k++) begin
            v = 0;
            for (int n = 0; n < (size ? 8 : 4); n++) v += (size ? t8[n][k] : t4[n][k]) * s[n];
            v = (v + (1 << (SH - 1))) >>> SH;
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
            res[k*WO +: WO] = v[WO-1:0];
        end
        return res;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [8*WX-1:0] rand_coef();
        logic [8*WX-1:0] c;
        int kind;
        kind = int'($urandom_range(0, 2));
        for (int i = 0; i < 8; i++) begin
            case (kind)
                0:       c[i*WX +: WX] = WX'($urandom);
                1:       c[i*WX +: WX] = WX'($urandom_range(0, 511) - 256);
                default: case ($urandom_range(0, 2))
                             0:       c[i*WX +: WX] = 16'h7fff;
                             1:       c[i*WX +: WX] = 16'h8000;
                             default: c[i*WX +: WX] = 16'h0000;
                         endcase
            endcase
        end
        return c;
    endfunction

    // Called at a negedge; returns at a negedge.
    task automatic send(input logic size, input logic [8*WX-1:0] coef,
                        input bit abort, input bit corr, input bit b2b);
        int w;
        int acc;
        exp_t e;
        w = 0;
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_mis++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
            return;
        end
        in_valid = 1'b1;
        in_size  = size;
        in_coef  = coef;
        acc = edges + 1;
        if (b2b) chk("b2b_accept_edge", 128'(acc), 128'(hs_edge + 1));
        if (!abort) begin
            e.data = ref_col(size, coef);
            e.size = size;
            e.acc  = acc;
            q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_coef  = rand_coef();
        in_size  = ~size;
        if (abort || corr) begin
            @(negedge clk);
            @(negedge clk);
            if (abort) begin
                rst = 1'b1;
                #1;
                chk("abort_in_ready", 128'(in_ready), 128'(1));
                chk("abort_mul_tag", 128'(mul_tag), 128'(0));
                chk("abort_mul_x", 128'({mul_x, mul_mode}), 128'(0));
                @(negedge clk);
                rst = 1'b0;
            end else begin
                chk("err_before_corrupt", 128'(err), 128'(err_exp));
                corrupt = 1'b1;
                @(negedge clk);
                corrupt = 1'b0;
                err_exp = 1'b1;
                chk("err_after_corrupt", 128'(err), 128'(1));
            end
        end
    endtask

    task automatic wait_empty();
        int w;
        w = 0;
        while (q.size() > 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL output_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
            hold   = 0;
        end else begin
            if (out_valid && !prev_v && stall_req) begin
                hold      = 5;
                stall_req = 1'b0;
            end
            if (hold > 0) begin
                out_ready = 1'b0;
                hold--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            if (out_valid) begin
                chk("in_ready_while_out", 128'(in_ready), 128'(0));
                if (!prev_v) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_mis++;
                        $display("FAIL unexpected_output: got %h expected none", out_data);
                    end else begin
                        chk("out_latency", 128'(edges), 128'(q[0].acc + (q[0].size ? 11 : 7)));
                    end
                    held = out_data;
                end else begin
                    chk("out_data_stable", out_data, held);
                end
                if (out_ready && q.size() > 0) begin
                    chk("out_data", out_data, q[0].data);
                    chk("out_size", 128'(out_size), 128'(q[0].size));
                    chk("err_at_output", 128'(err), 128'(err_exp));
                    hs_edge = edges + 1;
                    void'(q.pop_front());
                    prev_v = 1'b0;
                end else begin
                    prev_v = 1'b1;
                end
            end else begin
                prev_v = 1'b0;
            end
        end
    end

    initial begin
        logic [8*WX-1:0] c;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_out_size_err", 128'({out_size, err}), 128'(0));
        chk("rst_mul", 128'({mul_x, mul_mode, mul_tag}), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        c = '0; c[0*WX +: WX] = 16'd64;
        send(1'b1, c, 1'b0, 1'b0, 1'b0);
        c = '0; c[1*WX +: WX] = 16'd128; c[5*WX +: WX] = 16'd999;
        send(1'b0, c, 1'b0, 1'b0, 1'b0);
        c = '0; c[1*WX +: WX] = 16'd128;
        send(1'b1, c, 1'b0, 1'b0, 1'b0);
        c = {8{16'h7fff}};
        send(1'b1, c, 1'b0, 1'b0, 1'b0);
        wait_empty();

        stall_req = 1'b1;
        send(1'b1, rand_coef(), 1'b0, 1'b0, 1'b0);
        send(1'b0, rand_coef(), 1'b0, 1'b0, 1'b1);
        wait_empty();

        send(1'b1, rand_coef(), 1'b1, 1'b0, 1'b0);
        send(1'b1, rand_coef(), 1'b0, 1'b0, 1'b0);
        wait_empty();
        chk("err_after_abort", 128'(err), 128'(0));

        for (int i = 0; i < 40; i++) send(1'($urandom_range(0, 1)), rand_coef(), 1'b0, 1'b0, 1'b0);
        wait_empty();

        send(1'b1, rand_coef(), 1'b0, 1'b1, 1'b0);
        send(1'b0, rand_coef(), 1'b0, 1'b0, 1'b0);
        wait_empty();
        chk("err_sticky", 128'(err), 128'(1));

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        err_exp = 1'b0;
        chk("err_cleared_by_rst", 128'(err), 128'(0));
        send(1'b0, rand_coef(), 1'b0, 1'b0, 1'b0);
        send(1'b1, rand_coef(), 1'b0, 1'b0, 1'b0);
        wait_empty();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
